// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback phases.
// Latency: lw 5, sw 4, R/I/jal/lui 4, jalr 5, branch/auipc 3 cycles with zero-wait memory.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold with stable requests until MemReady.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       unsign,
  output logic       InstrDone,
  output logic       Illegal
);

  // RV32I major opcodes handled by this controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU source / op encodings
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_CMP    = 2'b11;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR1    = 4'd10,
    S_JALR2    = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t r_state;
  state_t w_next;

  // Branch funct3 010/011 are unassigned encodings and trap
  logic w_bad_branch;
  logic w_cond;
  logic w_taken;

  // Unqualified per-state decodes; enables are gated by reset at the ports
  logic       w_pcwrite;
  logic       w_adrsrc;
  logic       w_memreq;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_instrdone;
  logic       w_illegal;
  logic [1:0] w_resultsrc;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;

  assign w_bad_branch = (funct3[2:1] == 2'b01);

  // State register; reset forces FETCH immediately, abandoning any instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: memory states hold for MemReady, DECODE dispatches on opcode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD,
          OP_STORE:  w_next = S_MEMADR;
          OP_REG:    w_next = S_EXECR;
          OP_IMM:    w_next = S_EXECI;
          OP_BRANCH: w_next = w_bad_branch ? S_TRAP : S_BRANCH;
          OP_JAL:    w_next = S_JAL;
          OP_JALR:   w_next = S_JALR1;
          OP_LUI:    w_next = S_LUI;
          OP_AUIPC:  w_next = S_ALUWB;   // ALUOut already holds OldPC+imm
          default:   w_next = S_TRAP;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_JALR1:    w_next = S_JALR2;
      S_JALR2:    w_next = S_ALUWB;
      S_BRANCH:   w_next = S_FETCH;
      S_LUI:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // Branch resolution: funct3[2:1] picks the flag, funct3[0] inverts it
  always_comb begin
    w_cond = 1'b0;
    case (funct3[2:1])
      2'b00:   w_cond = Zero;
      2'b10:   w_cond = Lt;
      2'b11:   w_cond = Ltu;
      default: w_cond = 1'b0;
    endcase
    w_taken = ~w_bad_branch & (w_cond ^ funct3[0]);
  end

  // Per-state datapath selects and enables (Moore, except MemReady/branch gating)
  always_comb begin
    w_pcwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memreq    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_instrdone = 1'b0;
    w_illegal   = 1'b0;
    w_resultsrc = RES_ALUOUT;
    w_alusrca   = SRCA_PC;
    w_alusrcb   = SRCB_RS2;
    w_aluop     = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_memreq    = 1'b1;
        w_alusrca   = SRCA_PC;
        w_alusrcb   = SRCB_FOUR;
        w_aluop     = ALU_ADD;
        w_resultsrc = RES_ALURES;
        // PC+4 and IR load only on the cycle the fetch completes
        w_irwrite   = MemReady;
        w_pcwrite   = MemReady;
      end
      S_DECODE: begin
        // Precompute branch/jal/auipc target into ALUOut
        w_alusrca = SRCA_OLDPC;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_ADD;
      end
      S_MEMADR: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_ADD;
      end
      S_MEMREAD: begin
        w_adrsrc    = 1'b1;
        w_resultsrc = RES_ALUOUT;
        w_memreq    = 1'b1;
      end
      S_MEMWB: begin
        w_resultsrc = RES_DATA;
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc    = 1'b1;
        w_resultsrc = RES_ALUOUT;
        w_memreq    = 1'b1;
        w_memwrite  = 1'b1;
        w_instrdone = MemReady;
      end
      S_EXECR: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_RS2;
        w_aluop   = ALU_FUNCT;
      end
      S_EXECI: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        w_resultsrc = RES_ALUOUT;
        w_regwrite  = 1'b1;
        w_instrdone = 1'b1;
      end
      S_JAL, S_JALR2: begin
        // Link value OldPC+4 computed while PC loads the target from ALUOut
        w_alusrca   = SRCA_OLDPC;
        w_alusrcb   = SRCB_FOUR;
        w_aluop     = ALU_ADD;
        w_resultsrc = RES_ALUOUT;
        w_pcwrite   = 1'b1;
      end
      S_JALR1: begin
        w_alusrca = SRCA_RS1;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_ADD;
      end
      S_BRANCH: begin
        w_alusrca   = SRCA_RS1;
        w_alusrcb   = SRCB_RS2;
        w_resultsrc = RES_ALUOUT;
        w_aluop     = (funct3[2:1] == 2'b00) ? ALU_SUB : ALU_CMP;
        w_pcwrite   = w_taken;
        w_instrdone = 1'b1;
      end
      S_LUI: begin
        w_alusrca = SRCA_ZERO;
        w_alusrcb = SRCB_IMM;
        w_aluop   = ALU_ADD;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
      end
      default: begin
        w_illegal = 1'b0;
      end
    endcase
  end

  // Immediate format select decoded straight from the instruction fields
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_IMM:           ImmSrc = (funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      OP_JAL:           ImmSrc = 3'b011;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_STORE:         ImmSrc = 3'b001;
      default:          ImmSrc = 3'b000;
    endcase
  end

  // Unsigned compare for sltiu and bltu/bgeu
  always_comb begin
    unsign = 1'b0;
    if (op == OP_IMM && funct3[1:0] == 2'b11) begin
      unsign = 1'b1;
    end else if (op == OP_BRANCH && funct3[2:1] == 2'b11) begin
      unsign = 1'b1;
    end
  end

  // While reset is held every write/request is suppressed at once
  assign PCWrite   = w_pcwrite   & ~reset;
  assign IRWrite   = w_irwrite   & ~reset;
  assign MemReq    = w_memreq    & ~reset;
  assign MemWrite  = w_memwrite  & ~reset;
  assign RegWrite  = w_regwrite  & ~reset;
  assign InstrDone = w_instrdone & ~reset;
  assign Illegal   = w_illegal   & ~reset;
  assign AdrSrc    = w_adrsrc;
  assign ResultSrc = w_resultsrc;
  assign ALUSrcA   = w_alusrca;
  assign ALUSrcB   = w_alusrcb;
  assign ALUOp     = w_aluop;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle full output vector compared
// against hand-built expectations, one task per instruction class / scenario.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, Lt, Ltu, MemReady;
  logic       PCWrite, AdrSrc, MemReq, MemWrite, IRWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       RegWrite, unsign, InstrDone, Illegal;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemReq(MemReq), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .unsign(unsign),
    .InstrDone(InstrDone), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemReq,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,RegWrite,unsign,InstrDone,Illegal}
  logic [19:0] obs;
  assign obs = {PCWrite, AdrSrc, MemReq, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUOp, ImmSrc, RegWrite, unsign, InstrDone, Illegal};

  function automatic logic [19:0] pk(input logic pcw, adr, req, mw, irw,
                                     input logic [1:0] rs, a, b, aop,
                                     input logic [2:0] imm,
                                     input logic rw, u, d, il);
    return {pcw, adr, req, mw, irw, rs, a, b, aop, imm, rw, u, d, il};
  endfunction

  function automatic logic [19:0] fx(input logic rdy, input logic [2:0] imm, input logic u);
    return pk(rdy, 1'b0, 1'b1, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0, u, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] dx(input logic [2:0] imm, input logic u);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, u, 1'b0, 1'b0);
  endfunction

  function automatic logic [19:0] wb(input logic [2:0] imm, input logic u);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, u, 1'b1, 1'b0);
  endfunction

  // FETCH decodes with every enable and request suppressed by reset
  function automatic logic [19:0] rx(input logic [2:0] imm, input logic u);
    return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0, u, 1'b0, 1'b0);
  endfunction

  task automatic test_reset();
    reset = 1'b1; MemReady = 1'b1; op = 7'b0010011; funct3 = 3'b000;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (obs !== rx(3'b000, 1'b0)) begin
      n_errors++; $display("FAIL reset_hold: got %b expected %b", obs, rx(3'b000, 1'b0));
    end
    MemReady = 1'b0; reset = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (obs !== fx(1'b0, 3'b000, 1'b0)) begin
      n_errors++; $display("FAIL reset_release: got %b expected %b", obs, fx(1'b0, 3'b000, 1'b0));
    end
  endtask

  task automatic test_rtype();
    logic [19:0] e [0:4];
    logic [4:0]  rv = 5'b01111;
    op = 7'b0110011; funct3 = 3'b000;    // add x3,x1,x2 = 0x002081B3
    e[0] = fx(1'b1, 3'b000, 1'b0);
    e[1] = dx(3'b000, 1'b0);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 0, 0, 0, 0);
    e[3] = wb(3'b000, 1'b0);
    e[4] = fx(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL rtype_add cycle %0d: got %b expected %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [19:0] e [0:6];
    logic [6:0]  rv = 7'b0100111;        // MemReady low for two MEMREAD cycles
    logic [19:0] rd;
    op = 7'b0000011; funct3 = 3'b010;
    rd = pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0, 0, 0);
    e[0] = fx(1'b1, 3'b000, 1'b0);
    e[1] = dx(3'b000, 1'b0);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0);
    e[3] = rd; e[4] = rd; e[5] = rd;
    e[6] = pk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL lw_wait cycle %0d: got %b expected %b", i, obs, e[i]);
      end
    end
    @(negedge clk); MemReady = 1'b0; #1;
    n_checks++;
    if (obs !== fx(1'b0, 3'b000, 1'b0)) begin
      n_errors++; $display("FAIL lw_return: got %b expected %b", obs, fx(1'b0, 3'b000, 1'b0));
    end
  endtask

  task automatic test_store();
    logic [19:0] e [0:4];
    logic [4:0]  rv = 5'b01111;
    op = 7'b0100011; funct3 = 3'b010;
    e[0] = fx(1'b1, 3'b001, 1'b0);
    e[1] = dx(3'b001, 1'b0);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0, 0, 0, 0);
    e[3] = pk(0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0, 1, 0);
    e[4] = fx(1'b0, 3'b001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL sw cycle %0d: got %b expected %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_branch(input string name, input logic [2:0] f3,
                             input logic z, input logic lt, input logic ltu,
                             input logic pcw, input logic [1:0] aop, input logic u);
    logic [19:0] e [0:3];
    logic [3:0]  rv = 4'b0111;
    op = 7'b1100011; funct3 = f3; Zero = z; Lt = lt; Ltu = ltu;
    e[0] = fx(1'b1, 3'b010, u);
    e[1] = dx(3'b010, u);
    e[2] = pk(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, aop, 3'b010, 0, u, 1, 0);
    e[3] = fx(1'b0, 3'b010, u);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, e[i]);
      end
    end
  endtask

  task automatic test_jalr();
    logic [19:0] e [0:5];
    logic [5:0]  rv = 6'b011111;
    op = 7'b1100111; funct3 = 3'b000;    // jalr x1,0(x1) = 0x000080E7
    e[0] = fx(1'b1, 3'b000, 1'b0);
    e[1] = dx(3'b000, 1'b0);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 0, 0, 0, 0);
    e[3] = pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 0, 0, 0, 0);
    e[4] = wb(3'b000, 1'b0);
    e[5] = fx(1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL jalr cycle %0d: got %b expected %b", i, obs, e[i]);
      end
    end
  endtask

  // jal / lui: one execute-phase state between DECODE and ALUWB
  task automatic test_three_phase(input string name, input logic [6:0] opc,
                                  input logic [2:0] imm, input logic [19:0] mid);
    logic [19:0] e [0:4];
    logic [4:0]  rv = 5'b01111;
    op = opc; funct3 = 3'b000;
    e[0] = fx(1'b1, imm, 1'b0);
    e[1] = dx(imm, 1'b0);
    e[2] = mid;
    e[3] = wb(imm, 1'b0);
    e[4] = fx(1'b0, imm, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, e[i]);
      end
    end
  endtask

  task automatic test_auipc();
    logic [19:0] e [0:3];
    logic [3:0]  rv = 4'b0111;
    op = 7'b0010111; funct3 = 3'b000;
    e[0] = fx(1'b1, 3'b100, 1'b0);
    e[1] = dx(3'b100, 1'b0);
    e[2] = wb(3'b100, 1'b0);
    e[3] = fx(1'b0, 3'b100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL auipc cycle %0d: got %b expected %b", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_trap(input string name, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [2:0] imm, input int trap_cycles);
    logic [19:0] tv;
    op = opc; funct3 = f3;
    tv = pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0, 0, 0, 1);
    for (int i = 0; i < trap_cycles + 2; i++) begin
      @(negedge clk); MemReady = 1'b1; #1;
      n_checks++;
      if (i == 0) begin
        if (obs !== fx(1'b1, imm, 1'b0)) begin
          n_errors++; $display("FAIL %s fetch: got %b expected %b", name, obs, fx(1'b1, imm, 1'b0));
        end
      end else if (i == 1) begin
        if (obs !== dx(imm, 1'b0)) begin
          n_errors++; $display("FAIL %s decode: got %b expected %b", name, obs, dx(imm, 1'b0));
        end
      end else if (obs !== tv) begin
        n_errors++; $display("FAIL %s trap cycle %0d: got %b expected %b", name, i, obs, tv);
      end
    end
    @(negedge clk); MemReady = 1'b0; reset = 1'b1; #1;
    n_checks++;
    if (obs !== rx(imm, 1'b0)) begin
      n_errors++; $display("FAIL %s reset_in_trap: got %b expected %b", name, obs, rx(imm, 1'b0));
    end
    @(negedge clk); reset = 1'b0; #1;
    n_checks++;
    if (obs !== fx(1'b0, imm, 1'b0)) begin
      n_errors++; $display("FAIL %s after_trap: got %b expected %b", name, obs, fx(1'b0, imm, 1'b0));
    end
  endtask

  task automatic test_reset_in_memwrite();
    logic [19:0] e [0:4];
    logic [4:0]  rv = 5'b00111;
    op = 7'b0100011; funct3 = 3'b010;
    e[0] = fx(1'b1, 3'b001, 1'b0);
    e[1] = dx(3'b001, 1'b0);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b001, 0, 0, 0, 0);
    e[3] = pk(0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0, 0, 0);
    e[4] = e[3];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL sw_stall cycle %0d: got %b expected %b", i, obs, e[i]);
      end
    end
    // Mid-cycle assertion: the store strobe must vanish without a clock edge
    reset = 1'b1; #1;
    n_checks++;
    if (obs !== rx(3'b001, 1'b0)) begin
      n_errors++; $display("FAIL reset_in_memwrite: got %b expected %b", obs, rx(3'b001, 1'b0));
    end
    @(negedge clk); MemReady = 1'b0; reset = 1'b0; #1;
    n_checks++;
    if (obs !== fx(1'b0, 3'b001, 1'b0)) begin
      n_errors++; $display("FAIL fetch_after_reset: got %b expected %b", obs, fx(1'b0, 3'b001, 1'b0));
    end
  endtask

  task automatic test_execi(input string name, input logic [2:0] f3,
                            input logic [2:0] imm, input logic u);
    logic [19:0] e [0:4];
    logic [4:0]  rv = 5'b01111;
    op = 7'b0010011; funct3 = f3;
    e[0] = fx(1'b1, imm, u);
    e[1] = dx(imm, u);
    e[2] = pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, imm, 0, u, 0, 0);
    e[3] = wb(imm, u);
    e[4] = fx(1'b0, imm, u);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); MemReady = rv[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin
        n_errors++; $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, e[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; MemReady = 1'b0; op = 7'b0; funct3 = 3'b0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branch("bltu_taken",    3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b1);
    test_branch("bgeu_nottaken", 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1'b1);
    test_branch("beq_taken",     3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    test_branch("bne_nottaken",  3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    test_branch("bne_taken",     3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    test_branch("blt_taken",     3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    test_branch("blt_nottaken",  3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0);
    test_branch("bge_taken",     3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0);
    test_jalr();
    test_three_phase("jal", 7'b1101111, 3'b011,
                     pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b011, 0, 0, 0, 0));
    test_three_phase("lui", 7'b0110111, 3'b100,
                     pk(0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 2'b00, 3'b100, 0, 0, 0, 0));
    test_auipc();
    test_execi("srai",  3'b101, 3'b101, 1'b0);
    test_execi("sltiu", 3'b011, 3'b000, 1'b1);
    test_trap("trap_op0", 7'b0000000, 3'b000, 3'b000, 12);
    test_trap("trap_branch_f3_011", 7'b1100011, 3'b011, 3'b010, 2);
    test_reset_in_memwrite();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
